// File: rtl/fcn_axil_host.sv
`default_nettype none
// ============================================================================
// Module   : fcn_axil_host
// Desc     : AXI4-Lite register front end for the FCN inference core.
//            Holds the binary image, launches the core with a one-cycle
//            start pulse, captures the result class and counts the cycles
//            the inference took.
// Revision : 1.0 - initial release
// ============================================================================
module fcn_axil_host #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 8,
  parameter int IMG_BITS = 784
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ADDR_W-1:0]   s_awaddr,
  input  logic                s_awvalid,
  output logic                s_awready,
  input  logic [DATA_W-1:0]   s_wdata,
  input  logic [DATA_W/8-1:0] s_wstrb,
  input  logic                s_wvalid,
  output logic                s_wready,
  output logic [1:0]          s_bresp,
  output logic                s_bvalid,
  input  logic                s_bready,
  input  logic [ADDR_W-1:0]   s_araddr,
  input  logic                s_arvalid,
  output logic                s_arready,
  output logic [DATA_W-1:0]   s_rdata,
  output logic [1:0]          s_rresp,
  output logic                s_rvalid,
  input  logic                s_rready,
  output logic [IMG_BITS-1:0] fcn_image,
  output logic                fcn_start,
  input  logic [3:0]          fcn_class,
  input  logic                fcn_done,
  output logic                irq
);

  // Image geometry: words needed to hold the image, index width for them.
  // IMG_BITS is assumed to be a multiple of 8 so whole bytes map cleanly.
  localparam int c_NUM_WORDS = (IMG_BITS + DATA_W - 1) / DATA_W;
  localparam int c_K_W       = $clog2(c_NUM_WORDS);
  localparam int c_IDX_W     = ADDR_W - 2;

  // Word index decode of the register map
  localparam logic [c_IDX_W-1:0] c_IDX_CTRL   = c_IDX_W'(0);
  localparam logic [c_IDX_W-1:0] c_IDX_STATUS = c_IDX_W'(1);
  localparam logic [c_IDX_W-1:0] c_IDX_RESULT = c_IDX_W'(2);
  localparam logic [c_IDX_W-1:0] c_IDX_CYCLES = c_IDX_W'(3);
  localparam logic [c_IDX_W-1:0] c_IDX_IMG0   = c_IDX_W'(4);
  localparam logic [c_IDX_W-1:0] c_IDX_IMGN   = c_IDX_W'(4 + c_NUM_WORDS - 1);

  localparam logic [1:0] c_RESP_OKAY   = 2'b00;
  localparam logic [1:0] c_RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Register file
  logic [DATA_W-1:0]   r_img [c_NUM_WORDS];
  logic                r_ie;
  logic                r_done;
  logic [3:0]          r_result;
  logic [DATA_W-1:0]   r_cycles;
  logic                r_fcn_start;
  logic [IMG_BITS-1:0] r_fcn_image;
  logic [IMG_BITS-1:0] w_image_flat;

  // AXI channel registers
  logic                r_awready;
  logic                r_bvalid;
  logic [1:0]          r_bresp;
  logic                r_arready;
  logic                r_rvalid;
  logic [1:0]          r_rresp;
  logic [DATA_W-1:0]   r_rdata;

  // Decode / control wires
  logic                w_busy;
  logic                w_wr_fire;
  logic                w_rd_fire;
  logic                w_wr_pending;
  logic [c_IDX_W-1:0]  w_wr_idx;
  logic [c_IDX_W-1:0]  w_rd_idx;
  logic [c_K_W-1:0]    w_wr_k;
  logic [c_K_W-1:0]    w_rd_k;
  logic                w_wr_ctrl;
  logic                w_wr_status;
  logic                w_wr_img;
  logic                w_wr_mapped;
  logic                w_start_bit;
  logic                w_start_req;
  logic                w_img_wr;
  logic                w_ie_wr;
  logic                w_w1c;
  logic [1:0]          w_wr_resp;
  logic [DATA_W-1:0]   w_rd_data;
  logic [1:0]          w_rd_resp;
  logic                w_cyc_inc;
  logic                w_done_set;
  logic                w_unused;

  // The two low address bits are byte offsets inside a word and carry no meaning
  assign w_unused = ^{s_awaddr[1:0], s_araddr[1:0]};

  assign w_busy       = (r_state != ST_IDLE);
  assign w_wr_fire    = r_awready & s_awvalid & s_wvalid;
  assign w_rd_fire    = r_arready & s_arvalid;
  assign w_wr_pending = s_awvalid & s_wvalid & ~r_bvalid;

  // Write decode: start or image writes are refused while an inference runs,
  // but the ie bit of a refused CTRL beat is still applied.
  assign w_wr_idx    = s_awaddr[ADDR_W-1:2];
  assign w_wr_k      = c_K_W'(w_wr_idx - c_IDX_IMG0);
  assign w_wr_ctrl   = (w_wr_idx == c_IDX_CTRL);
  assign w_wr_status = (w_wr_idx == c_IDX_STATUS);
  assign w_wr_img    = (w_wr_idx >= c_IDX_IMG0) && (w_wr_idx <= c_IDX_IMGN);
  assign w_wr_mapped = (w_wr_idx <= c_IDX_CYCLES) || w_wr_img;
  assign w_start_bit = s_wstrb[0] & s_wdata[0];
  assign w_start_req = w_wr_fire & w_wr_ctrl & w_start_bit & ~w_busy;
  assign w_img_wr    = w_wr_fire & w_wr_img & ~w_busy;
  assign w_ie_wr     = w_wr_fire & w_wr_ctrl & s_wstrb[0];
  assign w_w1c       = w_wr_fire & w_wr_status & s_wstrb[0] & s_wdata[1];
  assign w_wr_resp   = (!w_wr_mapped || (w_busy && (w_wr_img || (w_wr_ctrl && w_start_bit))))
                       ? c_RESP_SLVERR : c_RESP_OKAY;

  assign w_rd_idx = s_araddr[ADDR_W-1:2];
  assign w_rd_k   = c_K_W'(w_rd_idx - c_IDX_IMG0);

  // Read data mux; unmapped addresses return zero with SLVERR
  always_comb begin
    w_rd_data = '0;
    w_rd_resp = c_RESP_OKAY;
    if (w_rd_idx == c_IDX_CTRL) begin
      w_rd_data = {{(DATA_W-2){1'b0}}, r_ie, 1'b0};
    end else if (w_rd_idx == c_IDX_STATUS) begin
      w_rd_data = {{(DATA_W-2){1'b0}}, r_done, w_busy};
    end else if (w_rd_idx == c_IDX_RESULT) begin
      w_rd_data = {{(DATA_W-4){1'b0}}, r_result};
    end else if (w_rd_idx == c_IDX_CYCLES) begin
      w_rd_data = r_cycles;
    end else if ((w_rd_idx >= c_IDX_IMG0) && (w_rd_idx <= c_IDX_IMGN)) begin
      for (int k = 0; k < c_NUM_WORDS; k++) begin
        if (w_rd_k == c_K_W'(k)) w_rd_data = r_img[k];
      end
    end else begin
      w_rd_resp = c_RESP_SLVERR;
    end
  end

  // Pixel p of the image (word p/32, bit p%32) drives bus bit IMG_BITS-1-p
  for (genvar p = 0; p < IMG_BITS; p++) begin : g_pix
    assign w_image_flat[IMG_BITS-1-p] = r_img[p / DATA_W][p % DATA_W];
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // FSM next state, cycle-count enable and completion detect
  always_comb begin
    w_state_nxt = r_state;
    w_cyc_inc   = 1'b0;
    w_done_set  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start_req) w_state_nxt = ST_ARM;
      end
      ST_ARM: begin
        // The core still shows the previous done until it takes the start
        w_cyc_inc = 1'b1;
        if (!fcn_done) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (fcn_done) begin
          w_done_set  = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_cyc_inc = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Image storage; bytes past the end of the image are never written and read 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < c_NUM_WORDS; k++) r_img[k] <= '0;
    end else if (w_img_wr) begin
      for (int k = 0; k < c_NUM_WORDS; k++) begin
        if (w_wr_k == c_K_W'(k)) begin
          for (int b = 0; b < DATA_W/8; b++) begin
            if (s_wstrb[b] && ((DATA_W*k + 8*b) < IMG_BITS))
              r_img[k][8*b +: 8] <= s_wdata[8*b +: 8];
          end
        end
      end
    end
  end

  // Control/status registers, result latch, saturating cycle counter, start pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ie        <= 1'b0;
      r_done      <= 1'b0;
      r_result    <= '0;
      r_cycles    <= '0;
      r_fcn_start <= 1'b0;
    end else begin
      r_fcn_start <= w_start_req;
      if (w_ie_wr) r_ie <= s_wdata[1];
      // A completion in the same cycle as a W1C leaves done set
      if (w_done_set)                r_done <= 1'b1;
      else if (w_start_req || w_w1c) r_done <= 1'b0;
      if (w_done_set) r_result <= fcn_class;
      if (w_start_req)                      r_cycles <= '0;
      else if (w_cyc_inc && (r_cycles != '1)) r_cycles <= r_cycles + 1'b1;
    end
  end

  // Image bus follows the registers while idle and is frozen during an inference
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_fcn_image <= '0;
    else if (!w_busy) r_fcn_image <= w_image_flat;
  end

  // Write channel: one-cycle ready once AW and W are both valid, response held until bready
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_awready <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= c_RESP_OKAY;
    end else begin
      r_awready <= ~r_awready & w_wr_pending;
      if (w_wr_fire) begin
        r_bvalid <= 1'b1;
        r_bresp  <= w_wr_resp;
      end else if (s_bready) begin
        r_bvalid <= 1'b0;
      end
    end
  end

  // Read channel: a waiting write always goes first
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rresp   <= c_RESP_OKAY;
      r_rdata   <= '0;
    end else begin
      r_arready <= ~r_arready & ~r_rvalid & s_arvalid & ~w_wr_pending & ~r_awready;
      if (w_rd_fire) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_rd_data;
        r_rresp  <= w_rd_resp;
      end else if (s_rready) begin
        r_rvalid <= 1'b0;
      end
    end
  end

  assign s_awready = r_awready;
  assign s_wready  = r_awready;
  assign s_bvalid  = r_bvalid;
  assign s_bresp   = r_bresp;
  assign s_arready = r_arready;
  assign s_rvalid  = r_rvalid;
  assign s_rresp   = r_rresp;
  assign s_rdata   = r_rdata;
  assign fcn_image = r_fcn_image;
  assign fcn_start = r_fcn_start;
  assign irq       = r_done & r_ie;

endmodule
`default_nettype wire

// File: tb/tb_fcn_axil_host.sv
`default_nettype none
// ============================================================================
// Module   : tb_fcn_axil_host
// Desc     : Self-checking bench for fcn_axil_host with a simple FCN core
//            model and a word-level register model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fcn_axil_host;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [7:0]   s_awaddr = '0;
  logic         s_awvalid = 1'b0;
  logic         s_awready;
  logic [31:0]  s_wdata = '0;
  logic [3:0]   s_wstrb = '0;
  logic         s_wvalid = 1'b0;
  logic         s_wready;
  logic [1:0]   s_bresp;
  logic         s_bvalid;
  logic         s_bready = 1'b0;
  logic [7:0]   s_araddr = '0;
  logic         s_arvalid = 1'b0;
  logic         s_arready;
  logic [31:0]  s_rdata;
  logic [1:0]   s_rresp;
  logic         s_rvalid;
  logic         s_rready = 1'b0;
  logic [783:0] fcn_image;
  logic         fcn_start;
  logic [3:0]   fcn_class = '0;
  logic         fcn_done = 1'b0;
  logic         irq;

  always #5 clk = ~clk;

  fcn_axil_host #(.DATA_W(32), .ADDR_W(8), .IMG_BITS(784)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .fcn_image(fcn_image), .fcn_start(fcn_start), .fcn_class(fcn_class),
    .fcn_done(fcn_done), .irq(irq)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Core model: takes start, drops done, raises done with the class core_lat cycles later
  int         core_lat = 900;
  logic [3:0] core_cls = 4'd7;
  int         core_cnt = 0;
  logic       core_run = 1'b0;
  always @(posedge clk) begin
    if (fcn_start) begin
      core_run <= 1'b1;
      core_cnt <= core_lat;
      fcn_done <= 1'b0;
    end else if (core_run) begin
      if (core_cnt <= 1) begin
        core_run  <= 1'b0;
        fcn_done  <= 1'b1;
        fcn_class <= core_cls;
      end else begin
        core_cnt <= core_cnt - 1;
      end
    end
  end

  // Number of cycles fcn_start has been seen high
  int n_start = 0;
  always @(negedge clk) if (fcn_start) n_start++;

  // Register model
  logic [31:0] m_img [25];
  logic        m_ie = 1'b0;

  function automatic logic [1:0] model_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] st);
    int idx = int'(a[7:2]);
    if (idx == 0) begin
      if (st[0]) m_ie = d[1];
      return 2'b00;
    end
    if (idx <= 3) return 2'b00;
    if (idx <= 28) begin
      for (int b = 0; b < 4; b++) if (st[b]) m_img[idx-4][8*b +: 8] = d[8*b +: 8];
      if (idx == 28) m_img[24][31:16] = 16'h0;
      return 2'b00;
    end
    return 2'b10;
  endfunction

  // Idle-state read model (no inference has run yet while this is used)
  function automatic void model_read(input logic [7:0] a, output logic [31:0] d, output logic [1:0] r);
    int idx = int'(a[7:2]);
    d = 32'h0;
    r = 2'b00;
    if (idx == 0)       d = {30'h0, m_ie, 1'b0};
    else if (idx <= 3)  d = 32'h0;
    else if (idx <= 28) d = m_img[idx-4];
    else                r = 2'b10;
  endfunction

  task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] st,
                           output logic [1:0] resp, input int hold);
    int   n;
    logic stable;
    @(negedge clk);
    s_awaddr = a; s_wdata = d; s_wstrb = st; s_awvalid = 1'b1; s_wvalid = 1'b1;
    n = 0;
    while (!(s_awready && s_wready) && n < 50) begin @(negedge clk); n++; end
    chk("aw_w_ready", 64'({s_awready, s_wready}), 64'h3);
    @(negedge clk);
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    chk("b_latency", 64'({s_awready, s_bvalid}), 64'h1);
    resp = s_bresp;
    stable = 1'b1;
    repeat (hold) begin
      @(negedge clk);
      if (s_bvalid !== 1'b1 || s_bresp !== resp) stable = 1'b0;
    end
    if (hold > 0) chk("bvalid_hold", 64'(stable), 64'h1);
    s_bready = 1'b1;
    @(negedge clk);
    s_bready = 1'b0;
  endtask

  task automatic axi_read(input logic [7:0] a, output logic [31:0] d, output logic [1:0] resp,
                          input int hold);
    int   n;
    logic stable;
    @(negedge clk);
    s_araddr = a; s_arvalid = 1'b1;
    n = 0;
    while (!s_arready && n < 50) begin @(negedge clk); n++; end
    chk("ar_ready", 64'(s_arready), 64'h1);
    @(negedge clk);
    s_arvalid = 1'b0;
    chk("r_latency", 64'({s_arready, s_rvalid}), 64'h1);
    d = s_rdata;
    resp = s_rresp;
    stable = 1'b1;
    repeat (hold) begin
      @(negedge clk);
      if (s_rvalid !== 1'b1 || s_rdata !== d || s_rresp !== resp) stable = 1'b0;
    end
    if (hold > 0) chk("rvalid_hold", 64'(stable), 64'h1);
    s_rready = 1'b1;
    @(negedge clk);
    s_rready = 1'b0;
  endtask

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp;
    logic [31:0] rdata;
    logic [1:0]  rresp;
  } vec_t;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d passed", n_pass, n_total);
    $fatal(1);
  end

  initial begin
    vec_t         vt [11];
    logic [1:0]   br, rr, er;
    logic [31:0]  rd, ed, d;
    logic [7:0]   a;
    logic [3:0]   st;
    logic [783:0] exp_img;
    int           n, s0, cyc, first_bad;

    vt[0]  = '{8'h10, 32'h0000_0001, 4'hF, 2'b00, 32'h0000_0001, 2'b00};
    vt[1]  = '{8'h70, 32'hFFFF_FFFF, 4'hF, 2'b00, 32'h0000_FFFF, 2'b00};
    vt[2]  = '{8'h24, 32'h1234_5678, 4'h5, 2'b00, 32'h0034_0078, 2'b00};
    vt[3]  = '{8'h17, 32'hA5A5_A5A5, 4'hF, 2'b00, 32'hA5A5_A5A5, 2'b00};
    vt[4]  = '{8'h00, 32'h0000_0002, 4'h1, 2'b00, 32'h0000_0002, 2'b00};
    vt[5]  = '{8'h00, 32'h0000_0000, 4'hE, 2'b00, 32'h0000_0002, 2'b00};
    vt[6]  = '{8'h80, 32'h1111_1111, 4'hF, 2'b10, 32'h0000_0000, 2'b10};
    vt[7]  = '{8'h74, 32'h2222_2222, 4'hF, 2'b10, 32'h0000_0000, 2'b10};
    vt[8]  = '{8'h08, 32'h0000_000F, 4'hF, 2'b00, 32'h0000_0000, 2'b00};
    vt[9]  = '{8'h6C, 32'hCAFE_F00D, 4'h8, 2'b00, 32'hCA00_0000, 2'b00};
    vt[10] = '{8'h00, 32'h0000_0000, 4'hF, 2'b00, 32'h0000_0000, 2'b00};

    // ---------------- reset state ----------------
    repeat (3) @(negedge clk);
    chk("rst_handshakes", 64'({s_awready, s_wready, s_bvalid, s_arready, s_rvalid}), 64'h0);
    chk("rst_resp", 64'({s_bresp, s_rresp}), 64'h0);
    chk("rst_rdata", 64'(s_rdata), 64'h0);
    chk("rst_core_if", 64'({fcn_start, irq, |fcn_image}), 64'h0);
    rst_n = 1'b1;
    axi_read(8'h04, rd, rr, 0);
    chk("rst_status", 64'({rr, rd}), 64'h0);

    // ---------------- table vectors ----------------
    for (int i = 0; i < 11; i++) begin
      axi_write(vt[i].addr, vt[i].wdata, vt[i].wstrb, br, 0);
      chk($sformatf("vec%0d_bresp", i), 64'(br), 64'(vt[i].bresp));
      axi_read(vt[i].addr, rd, rr, 0);
      chk($sformatf("vec%0d_rdata", i), 64'(rd), 64'(vt[i].rdata));
      chk($sformatf("vec%0d_rresp", i), 64'(rr), 64'(vt[i].rresp));
    end

    // ---------------- randomized register traffic vs model ----------------
    for (int k = 0; k < 25; k++) begin
      axi_write(8'(16 + 4*k), 32'h0, 4'hF, br, 0);
      m_img[k] = 32'h0;
    end
    m_ie = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) != 0) a = 8'(16 + 4*$urandom_range(0, 24));
      else                           a = 8'($urandom_range(0, 255));
      a[1:0] = 2'($urandom);
      d  = $urandom;
      st = 4'($urandom);
      if (a[7:2] == 6'd0) d[0] = 1'b0;
      er = model_write(a, d, st);
      axi_write(a, d, st, br, 0);
      chk($sformatf("rnd%0d_bresp@%0h", i, a), 64'(br), 64'(er));
      a = ($urandom_range(0, 3) != 0) ? 8'(16 + 4*$urandom_range(0, 24)) : 8'($urandom_range(0, 255));
      model_read(a, ed, er);
      axi_read(a, rd, rr, 0);
      chk($sformatf("rnd%0d_rdata@%0h", i, a), 64'({rr, rd}), 64'({er, ed}));
    end
    for (int p = 0; p < 784; p++) exp_img[783-p] = m_img[p/32][p%32];
    first_bad = -1;
    for (int p = 783; p >= 0; p--) if (fcn_image[p] !== exp_img[p]) first_bad = p;
    n_total++;
    if (first_bad < 0) n_pass++;
    else $display("FAIL fcn_image_map: bit %0d got %b, expected %b", first_bad,
                  fcn_image[first_bad], exp_img[first_bad]);

    // ---------------- image boundary words ----------------
    axi_write(8'h10, 32'h0000_0001, 4'hF, br, 0);
    er = model_write(8'h10, 32'h0000_0001, 4'hF);
    axi_write(8'h70, 32'hFFFF_FFFF, 4'hF, br, 0);
    er = model_write(8'h70, 32'hFFFF_FFFF, 4'hF);
    axi_read(8'h70, rd, rr, 0);
    chk("img24_read", 64'(rd), 64'h0000_FFFF);
    chk("img_pixel0", 64'(fcn_image[783]), 64'h1);
    chk("img_last16", 64'(fcn_image[15:0]), 64'hFFFF);

    // ---------------- full inference ----------------
    core_lat = 900;
    core_cls = 4'd7;
    s0 = n_start;
    axi_write(8'h00, 32'h3, 4'hF, br, 0);
    chk("start_bresp", 64'(br), 64'h0);
    axi_read(8'h04, rd, rr, 0);
    chk("status_busy", 64'(rd), 64'h1);
    chk("irq_while_busy", 64'(irq), 64'h0);
    axi_write(8'h1C, 32'hDEAD_BEEF, 4'hF, br, 0);
    chk("busy_img_bresp", 64'(br), 64'h2);
    axi_write(8'h00, 32'h3, 4'hF, br, 0);
    chk("busy_start_bresp", 64'(br), 64'h2);
    axi_read(8'h1C, rd, rr, 0);
    chk("busy_img_unchanged", 64'(rd), 64'(m_img[3]));
    n = 0;
    while (!irq && n < 3000) begin @(negedge clk); n++; end
    chk("irq_on_done", 64'(irq), 64'h1);
    chk("one_start_pulse", 64'(n_start - s0), 64'h1);
    axi_read(8'h04, rd, rr, 0);
    chk("status_done", 64'(rd), 64'h2);
    axi_read(8'h08, rd, rr, 0);
    chk("result_class", 64'(rd), 64'h7);
    axi_read(8'h0C, rd, rr, 0);
    cyc = int'(rd);
    n_total++;
    if (cyc >= core_lat - 2 && cyc <= core_lat + 2) n_pass++;
    else $display("FAIL cycles: got %0d, required %0d..%0d", cyc, core_lat - 2, core_lat + 2);

    // ---------------- W1C and unmapped read ----------------
    axi_write(8'h04, 32'h2, 4'hF, br, 0);
    axi_read(8'h04, rd, rr, 0);
    chk("w1c_status", 64'(rd), 64'h0);
    chk("w1c_irq", 64'(irq), 64'h0);
    axi_read(8'h80, rd, rr, 0);
    chk("unmapped_read", 64'({rr, rd}), 64'h2_0000_0000);

    // ---------------- response back-pressure ----------------
    axi_write(8'h80, 32'h0, 4'hF, br, 5);
    chk("hold_bresp", 64'(br), 64'h2);
    axi_read(8'h10, rd, rr, 5);
    chk("hold_rdata", 64'(rd), 64'h1);

    // ---------------- simultaneous write and read: write goes first ----------------
    fork
      axi_write(8'h2C, 32'h55AA_33CC, 4'hF, br, 0);
      axi_read(8'h2C, rd, rr, 0);
    join
    chk("wr_before_rd", 64'(rd), 64'h55AA_33CC);

    // ---------------- second start, ie write while busy, reset mid-run ----------------
    axi_write(8'h00, 32'h3, 4'hF, br, 0);
    repeat (50) @(negedge clk);
    axi_read(8'h0C, rd, rr, 0);
    n_total++;
    if (rd < 32'd100) n_pass++;
    else $display("FAIL cycles_restart: got %0d, required below 100", rd);
    axi_write(8'h00, 32'h1, 4'hF, br, 0);
    chk("busy_ie_bresp", 64'(br), 64'h2);
    axi_read(8'h00, rd, rr, 0);
    chk("busy_ie_taken", 64'(rd), 64'h0);
    axi_read(8'h04, rd, rr, 0);
    chk("status_run", 64'(rd), 64'h1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrun_rst_outputs", 64'({fcn_start, irq, |fcn_image, s_bvalid, s_rvalid}), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    axi_read(8'h04, rd, rr, 0);
    chk("midrun_rst_status", 64'(rd), 64'h0);
    axi_read(8'h08, rd, rr, 0);
    chk("midrun_rst_result", 64'(rd), 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
